// File: rtl/reg_bus_master_if.sv
// Host byte streams plus the 6-bit-address register bus, bundled for reg_bus_master.
interface reg_bus_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;

  modport master (
    input  rx_data, rx_valid, tx_ready, reg_datao, reg_hyplen,
    output rx_ready, tx_data, tx_valid, reg_address, reg_bytecnt, reg_datai,
           reg_size, reg_read, reg_write, reg_addrvalid, reg_hypaddress
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, reg_datao, reg_hyplen,
    input  rx_ready, tx_data, tx_valid, reg_address, reg_bytecnt, reg_datai,
           reg_size, reg_read, reg_write, reg_addrvalid, reg_hypaddress
  );
endinterface

// File: rtl/reg_bus_master.sv
// Register bus initiator: decodes {rw,0,addr} / len_lo / len_hi [/ data...] host commands into reg_* strobes.
// Optional mid-command abort timer enabled by defining REG_MASTER_TIMEOUT_EN.
//  state      | meaning
//  IDLE       | waiting for command byte
//  LEN_LO/HI  | collecting length; zero length falls back to reg_hyplen
//  WR_DATA    | one reg_write per accepted data byte (strobe the cycle after acceptance)
//  RD_ISSUE   | reg_read strobe; RD_WAIT slave latency; RD_CAPTURE latch reg_datao
//  RD_SEND    | holding tx byte until the host accepts it
//  DONE       | closing the transaction, one cycle
module reg_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset_i,
  reg_bus_master_if.master bus,
  output logic busy,
  output logic timeout_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_WR_DATA,
    S_RD_ISSUE, S_RD_WAIT, S_RD_CAPTURE, S_RD_SEND, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [5:0]  addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] bytecnt_q, bytecnt_d;
  logic [7:0]  datai_q, datai_d;
  logic        write_q, write_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        addrvalid_q, addrvalid_d;
  logic [15:0] size_q, size_d;
  logic        timeout_q, timeout_d;

  logic        rx_ready;
  logic        rx_fire;
  logic        tx_fire;
  logic        timeout_hit;
  logic [15:0] len_full;
  logic [15:0] len_eff;

  assign rx_ready = ~reset_i & ((state_q == S_IDLE) | (state_q == S_LEN_LO) |
                                (state_q == S_LEN_HI) | (state_q == S_WR_DATA));
  assign rx_fire  = bus.rx_valid & rx_ready;
  assign tx_fire  = tx_valid_q & bus.tx_ready;
  assign len_full = {bus.rx_data, len_q[7:0]};
  assign len_eff  = (len_full == 16'd0) ? bus.reg_hyplen : len_full;

`ifdef REG_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt_q, idle_cnt_d;

  assign timeout_hit = (state_q != S_IDLE) & ~rx_fire & ~tx_fire & (idle_cnt_q == TO_LAST);

  always_comb begin
    idle_cnt_d = idle_cnt_q + 16'd1;
    if ((state_q == S_IDLE) || rx_fire || tx_fire || timeout_hit) idle_cnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (reset_i) idle_cnt_q <= 16'd0;
    else         idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    bytecnt_d   = bytecnt_q;
    datai_d     = datai_q;
    write_d     = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    addrvalid_d = addrvalid_q;
    size_d      = size_q;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          rw_d    = bus.rx_data[7];
          addr_d  = bus.rx_data[5:0];
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_fire) begin
          len_d   = {8'h00, bus.rx_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_fire) begin
          len_d     = len_eff;
          cnt_d     = 16'd0;
          bytecnt_d = 16'd0;
          if (len_eff == 16'd0) begin
            state_d = S_DONE;
          end else begin
            size_d      = len_eff;
            addrvalid_d = 1'b1;
            state_d     = rw_q ? S_RD_ISSUE : S_WR_DATA;
          end
        end
      end
      S_WR_DATA: begin
        // The last strobe lands in DONE, while reg_addrvalid is still high.
        if (rx_fire) begin
          write_d   = 1'b1;
          datai_d   = bus.rx_data;
          bytecnt_d = cnt_q;
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) state_d = S_DONE;
        end
      end
      S_RD_ISSUE:   state_d = S_RD_WAIT;
      S_RD_WAIT:    state_d = S_RD_CAPTURE;
      S_RD_CAPTURE: begin
        tx_data_d  = bus.reg_datao;
        tx_valid_d = 1'b1;
        state_d    = S_RD_SEND;
      end
      S_RD_SEND: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          if (bytecnt_q == len_q - 16'd1) begin
            state_d = S_DONE;
          end else begin
            bytecnt_d = bytecnt_q + 16'd1;
            state_d   = S_RD_ISSUE;
          end
        end
      end
      S_DONE: begin
        addrvalid_d = 1'b0;
        size_d      = 16'd0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      state_d     = S_IDLE;
      write_d     = 1'b0;
      tx_valid_d  = 1'b0;
      addrvalid_d = 1'b0;
      size_d      = 16'd0;
      timeout_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      addr_q      <= 6'd0;
      len_q       <= 16'd0;
      cnt_q       <= 16'd0;
      bytecnt_q   <= 16'd0;
      datai_q     <= 8'd0;
      write_q     <= 1'b0;
      tx_data_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      addrvalid_q <= 1'b0;
      size_q      <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      bytecnt_q   <= bytecnt_d;
      datai_q     <= datai_d;
      write_q     <= write_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      addrvalid_q <= addrvalid_d;
      size_q      <= size_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.rx_ready       = rx_ready;
  assign bus.tx_data        = tx_data_q;
  assign bus.tx_valid       = tx_valid_q;
  assign bus.reg_address    = addr_q;
  assign bus.reg_hypaddress = addr_q;
  assign bus.reg_bytecnt    = bytecnt_q;
  assign bus.reg_datai      = datai_q;
  assign bus.reg_size       = size_q;
  assign bus.reg_write      = write_q;
  assign bus.reg_read       = (state_q == S_RD_ISSUE);
  assign bus.reg_addrvalid  = addrvalid_q;
  assign busy               = (state_q != S_IDLE);
  assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master: expected strobes/tx bytes queued at stimulus time, checked per scenario.
module tb_reg_bus_master;
  logic clk = 1'b0;
  logic reset_i;
  logic busy;
  logic timeout_o;

  reg_bus_master_if bus();

  reg_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_i(reset_i), .bus(bus.master), .busy(busy), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] cnt;
    logic [7:0]  data;
    logic        av;
    logic [15:0] size;
  } wr_t;

  int checks = 0;
  int failures = 0;
  wr_t         wr_obs[$];
  wr_t         wr_exp[$];
  logic [7:0]  tx_obs[$];
  logic [7:0]  tx_exp[$];
  logic [15:0] rd_cnt_obs[$];
  int rd_pulses = 0;
  int overlaps = 0;
  int to_pulses = 0;

  // Register slave: read data appears the cycle after reg_read.
  always @(posedge clk) begin
    if (reset_i) bus.reg_datao <= 8'h00;
    else if (bus.reg_read) bus.reg_datao <= {bus.reg_bytecnt[3:0], 4'h0};
  end

  always @(negedge clk) begin
    if (bus.reg_write)
      wr_obs.push_back({bus.reg_address, bus.reg_bytecnt, bus.reg_datai, bus.reg_addrvalid, bus.reg_size});
    if (bus.reg_read) begin
      rd_pulses <= rd_pulses + 1;
      rd_cnt_obs.push_back(bus.reg_bytecnt);
    end
    if (bus.reg_read && bus.reg_write) overlaps <= overlaps + 1;
    if (bus.tx_valid && bus.tx_ready) tx_obs.push_back(bus.tx_data);
    if (timeout_o) to_pulses <= to_pulses + 1;
  end

  function automatic logic [7:0] slave_val(input logic [15:0] k);
    return {k[3:0], 4'h0};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.rx_ready) begin
      checks++; failures++;
      $display("FAIL rx_accept_timeout byte=%02h rx_ready=%b required=1", b, bus.rx_ready);
    end
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle busy=%b required=0 after %0d cycles", busy, budget);
    end
    step();
    step();
  endtask

  task automatic clear_sb();
    wr_obs.delete(); wr_exp.delete();
    tx_obs.delete(); tx_exp.delete();
    rd_cnt_obs.delete();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, bus.rx_ready, bus.tx_valid, bus.reg_write, bus.reg_read, bus.reg_addrvalid, timeout_o} !== 7'd0) begin
      failures++;
      $display("FAIL reset_strobes got=%b required=0000000",
               {busy, bus.rx_ready, bus.tx_valid, bus.reg_write, bus.reg_read, bus.reg_addrvalid, timeout_o});
    end
    checks++;
    if ({bus.reg_address, bus.reg_size, bus.reg_bytecnt, bus.reg_datai, bus.tx_data} !== 54'd0) begin
      failures++;
      $display("FAIL reset_buses addr=%0d size=%0d cnt=%0d datai=%02h tx=%02h required=0",
               bus.reg_address, bus.reg_size, bus.reg_bytecnt, bus.reg_datai, bus.tx_data);
    end
    reset_i = 1'b0;
    step();
    checks++;
    if (bus.rx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset rx_ready=%b busy=%b required=1/0", bus.rx_ready, busy);
    end
  endtask

  task automatic test_write();
    logic [7:0] data[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    wr_t e, o;
    clear_sb();
    send_byte(8'h35); send_byte(8'h04); send_byte(8'h00);
    for (int k = 0; k < 4; k++) begin
      wr_exp.push_back({6'd53, 16'(k), data[k], 1'b1, 16'd4});
      send_byte(data[k]);
    end
    wait_idle(50);
    checks++;
    if (wr_obs.size() != 4) begin
      failures++;
      $display("FAIL write_count got=%0d required=4", wr_obs.size());
    end
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front();
      o = (wr_obs.size() > 0) ? wr_obs.pop_front() : '0;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL write_strobe got addr=%0d cnt=%0d data=%02h av=%b size=%0d required addr=%0d cnt=%0d data=%02h av=%b size=%0d",
                 o.addr, o.cnt, o.data, o.av, o.size, e.addr, e.cnt, e.data, e.av, e.size);
      end
    end
    checks++;
    if (bus.reg_addrvalid !== 1'b0 || bus.reg_size !== 16'd0 || bus.reg_address !== 6'd53) begin
      failures++;
      $display("FAIL write_done av=%b size=%0d addr=%0d required 0/0/53",
               bus.reg_addrvalid, bus.reg_size, bus.reg_address);
    end
  endtask

  task automatic test_read();
    int r0 = rd_pulses;
    int v0 = overlaps;
    logic [7:0] e, o;
    clear_sb();
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) tx_exp.push_back(slave_val(16'(k)));
    send_byte(8'hB5); send_byte(8'h04); send_byte(8'h00);
    wait_idle(100);
    checks++;
    if (rd_pulses - r0 != 4 || tx_obs.size() != 4) begin
      failures++;
      $display("FAIL read_counts reads=%0d tx=%0d required=4/4", rd_pulses - r0, tx_obs.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_cnt_obs.size() == 0 || rd_cnt_obs[0] !== 16'(k)) begin
        failures++;
        $display("FAIL read_bytecnt index=%0d got=%0d required=%0d", k,
                 (rd_cnt_obs.size() > 0) ? rd_cnt_obs[0] : 16'hFFFF, k);
      end
      if (rd_cnt_obs.size() > 0) void'(rd_cnt_obs.pop_front());
    end
    while (tx_exp.size() > 0) begin
      e = tx_exp.pop_front();
      o = (tx_obs.size() > 0) ? tx_obs.pop_front() : 8'hXX;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL read_tx got=%02h required=%02h", o, e);
      end
    end
    checks++;
    if (overlaps != v0) begin
      failures++;
      $display("FAIL read_write_overlap got=%0d required=0", overlaps - v0);
    end
  endtask

  task automatic test_hyplen();
    int r0 = rd_pulses;
    clear_sb();
    bus.reg_hyplen = 16'd1;
    send_byte(8'hB6);
    checks++;
    if (bus.reg_hypaddress !== 6'd54) begin
      failures++;
      $display("FAIL hypaddress got=%0d required=54", bus.reg_hypaddress);
    end
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (bus.reg_size !== 16'd1 || bus.reg_addrvalid !== 1'b1) begin
      failures++;
      $display("FAIL hyplen_size size=%0d av=%b required=1/1", bus.reg_size, bus.reg_addrvalid);
    end
    wait_idle(50);
    checks++;
    if (rd_pulses - r0 != 1 || tx_obs.size() != 1 || (tx_obs.size() > 0 && tx_obs[0] !== slave_val(16'd0))) begin
      failures++;
      $display("FAIL hyplen_one reads=%0d tx=%0d required=1/1 byte 00", rd_pulses - r0, tx_obs.size());
    end
    clear_sb();
    r0 = rd_pulses;
    bus.reg_hyplen = 16'd0;
    send_byte(8'hB6); send_byte(8'h00); send_byte(8'h00);
    wait_idle(20);
    checks++;
    if (rd_pulses - r0 != 0 || tx_obs.size() != 0 || wr_obs.size() != 0) begin
      failures++;
      $display("FAIL hyplen_zero reads=%0d tx=%0d writes=%0d required=0/0/0",
               rd_pulses - r0, tx_obs.size(), wr_obs.size());
    end
  endtask

  task automatic test_tx_stall();
    int r0 = rd_pulses;
    int n = 0;
    int unstable = 0;
    logic [7:0] held;
    clear_sb();
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) tx_exp.push_back(slave_val(16'(k)));
    send_byte(8'hB5); send_byte(8'h04); send_byte(8'h00);
    while (tx_obs.size() < 2 && n < 100) begin step(); n++; end
    bus.tx_ready = 1'b0;
    n = 0;
    while (!bus.tx_valid && n < 20) begin step(); n++; end
    held = bus.tx_data;
    checks++;
    if (held !== slave_val(16'd2)) begin
      failures++;
      $display("FAIL stall_byte got=%02h required=%02h", held, slave_val(16'd2));
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.tx_data !== held || bus.tx_valid !== 1'b1) unstable++;
    end
    checks++;
    if (unstable != 0 || rd_pulses - r0 != 3) begin
      failures++;
      $display("FAIL stall_hold unstable=%0d reads=%0d required=0/3", unstable, rd_pulses - r0);
    end
    bus.tx_ready = 1'b1;
    wait_idle(100);
    checks++;
    if (rd_pulses - r0 != 4 || tx_obs.size() != 4) begin
      failures++;
      $display("FAIL stall_resume reads=%0d tx=%0d required=4/4", rd_pulses - r0, tx_obs.size());
    end
    while (tx_exp.size() > 0) begin
      held = tx_exp.pop_front();
      checks++;
      if (tx_obs.size() == 0 || tx_obs[0] !== held) begin
        failures++;
        $display("FAIL stall_tx got=%02h required=%02h", (tx_obs.size() > 0) ? tx_obs[0] : 8'hXX, held);
      end
      if (tx_obs.size() > 0) void'(tx_obs.pop_front());
    end
  endtask

  task automatic test_reset_mid_write();
    wr_t e, o;
    clear_sb();
    wr_exp.push_back({6'd53, 16'd0, 8'hAA, 1'b1, 16'd4});
    wr_exp.push_back({6'd53, 16'd1, 8'hBB, 1'b1, 16'd4});
    send_byte(8'h35); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    reset_i = 1'b1;
    step();
    checks++;
    if ({busy, bus.tx_valid, bus.reg_write, bus.reg_read, bus.reg_addrvalid, bus.rx_ready} !== 6'd0 ||
        {bus.reg_size, bus.reg_bytecnt, bus.reg_address, bus.reg_datai} !== 46'd0) begin
      failures++;
      $display("FAIL reset_mid_write busy=%b wr=%b av=%b size=%0d cnt=%0d addr=%0d required all 0",
               busy, bus.reg_write, bus.reg_addrvalid, bus.reg_size, bus.reg_bytecnt, bus.reg_address);
    end
    reset_i = 1'b0;
    step();
    wr_exp.push_back({6'd18, 16'd0, 8'h5A, 1'b1, 16'd1});
    send_byte(8'h12); send_byte(8'h01); send_byte(8'h00); send_byte(8'h5A);
    wait_idle(30);
    checks++;
    if (wr_obs.size() != 3) begin
      failures++;
      $display("FAIL reset_write_count got=%0d required=3", wr_obs.size());
    end
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front();
      o = (wr_obs.size() > 0) ? wr_obs.pop_front() : '0;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_write_strobe got addr=%0d cnt=%0d data=%02h required addr=%0d cnt=%0d data=%02h",
                 o.addr, o.cnt, o.data, e.addr, e.cnt, e.data);
      end
    end
  endtask

`ifdef REG_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int t0 = to_pulses;
    int n = 0;
    send_byte(8'h35); send_byte(8'h02);
    while (to_pulses == t0 && n < 40) begin step(); n++; end
    checks++;
    if (to_pulses - t0 != 1 || n < 14 || n > 20) begin
      failures++;
      $display("FAIL timeout_pulse pulses=%0d cycles=%0d required=1 near 16", to_pulses - t0, n);
    end
    step();
    checks++;
    if (busy !== 1'b0 || bus.reg_addrvalid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle busy=%b av=%b required=0/0", busy, bus.reg_addrvalid);
    end
  endtask
`else
  task automatic test_stall_no_timeout();
    int t0 = to_pulses;
    wr_t e, o;
    clear_sb();
    send_byte(8'h35); send_byte(8'h02);
    repeat (40) step();
    checks++;
    if (busy !== 1'b1 || to_pulses != t0) begin
      failures++;
      $display("FAIL stalled_wait busy=%b timeouts=%0d required=1/0", busy, to_pulses - t0);
    end
    send_byte(8'h00);
    wr_exp.push_back({6'd53, 16'd0, 8'hA1, 1'b1, 16'd2});
    send_byte(8'hA1);
    wr_exp.push_back({6'd53, 16'd1, 8'hB2, 1'b1, 16'd2});
    send_byte(8'hB2);
    wait_idle(30);
    while (wr_exp.size() > 0) begin
      e = wr_exp.pop_front();
      o = (wr_obs.size() > 0) ? wr_obs.pop_front() : '0;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stalled_write got cnt=%0d data=%02h size=%0d required cnt=%0d data=%02h size=%0d",
                 o.cnt, o.data, o.size, e.cnt, e.data, e.size);
      end
    end
  endtask
`endif

  initial begin
    reset_i        = 1'b1;
    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.tx_ready   = 1'b0;
    bus.reg_hyplen = 16'd0;
    step();
    test_reset();
    test_write();
    test_read();
    test_hyplen();
    test_tx_stall();
    test_reset_mid_write();
`ifdef REG_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_stall_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached time=%0t required finish earlier", $time);
    $fatal(1, "simulation time limit");
  end
endmodule
